qkv_feeder: RTL and testbench

QKV_FEEDER -- requirements
Module: qkv_feeder

---
 rtl/qkv_feeder_pkg.sv | 22 ++
 rtl/qkv_feeder_vec_fifo2.sv | 50 +++++
 rtl/qkv_feeder.sv | 192 +++++++++++++++++++
 tb/tb_qkv_feeder.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qkv_feeder_pkg.sv
// Shared vector types and helpers for the QKV feeder that streams SRAM rows
// into the attention PE.
package qkv_feeder_pkg;

   localparam int MAX_EMBEDDING_DIM = 4;
   localparam int ELEM_W            = 8;

   typedef logic [MAX_EMBEDDING_DIM-1:0][ELEM_W-1:0] Q_VECTOR_T;
   typedef logic [MAX_EMBEDDING_DIM-1:0][ELEM_W-1:0] K_VECTOR_T;
   typedef logic [MAX_EMBEDDING_DIM-1:0][ELEM_W-1:0] V_VECTOR_T;

   // A 2-entry buffer can take one more read if, after this cycle's pop,
   // stored entries plus the read already in flight leave a slot free.
   function automatic logic fifo_has_slot(input logic [1:0] count,
                                          input logic       pending,
                                          input logic       popping);
      logic [2:0] used;
      used = {1'b0, count} + {2'b00, pending} - {2'b00, popping};
      return used < 3'd2;
   endfunction

endpackage

// File: rtl/qkv_feeder_vec_fifo2.sv
// Two-entry valid/ready FIFO, parameterized by payload type; output data
// comes straight from storage so it stays stable while valid is held.
module vec_fifo2
   import qkv_feeder_pkg::*;
#(
   parameter type T = logic
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_en,
   input  T           wr_data,
   input  logic       rd_rdy,
   output logic       rd_vld,
   output T           rd_data,
   output logic [1:0] count
);

   T     mem [0:1];
   logic rd_ptr;
   logic wr_ptr;
   logic wr_ok;
   logic pop;

   assign rd_vld  = (count != 2'd0);
   assign rd_data = mem[rd_ptr];
   assign pop     = rd_vld && rd_rdy;
   assign wr_ok   = wr_en && (count != 2'd2);

   // Circular storage with a 1-bit pointer per side; writes to a full
   // buffer are dropped, the feeder's credit check keeps that from happening.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + {1'b0, wr_ok} - {1'b0, pop};
      end
   end

endmodule

// File: rtl/qkv_feeder.sv
// Streams one Q row followed by every K/V row per query from three SRAMs to
// the PE, with independent valid/ready handshakes per stream.
module qkv_feeder
   import qkv_feeder_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W:0]   num_q,
   input  logic [ADDR_W:0]   num_kv,
   output logic              busy,
   output logic              done,
   output logic              q_sram_ren,
   output logic [ADDR_W-1:0] q_sram_addr,
   input  Q_VECTOR_T         q_sram_rdata,
   output logic              k_sram_ren,
   output logic [ADDR_W-1:0] k_sram_addr,
   input  K_VECTOR_T         k_sram_rdata,
   output logic              v_sram_ren,
   output logic [ADDR_W-1:0] v_sram_addr,
   input  V_VECTOR_T         v_sram_rdata,
   output logic              Q_vld_out,
   input  logic              Q_rdy_in,
   output Q_VECTOR_T         q_vector,
   output logic              K_vld_out,
   input  logic              K_rdy_in,
   output K_VECTOR_T         k_vector,
   output logic              V_vld_out,
   input  logic              V_rdy_in,
   output V_VECTOR_T         v_vector
);

   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

   localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

   state_t          state;
   logic [ADDR_W:0] nq_lat;
   logic [ADDR_W:0] nkv_lat;
   logic [ADDR_W:0] q_row;
   logic [ADDR_W:0] kv_rd_cnt;
   logic [ADDR_W:0] k_hs_cnt;
   logic [ADDR_W:0] v_hs_cnt;
   logic [ADDR_W:0] k_hs_next;
   logic [ADDR_W:0] v_hs_next;
   logic            q_rd_pend;
   logic            q_done;
   logic            q_done_next;
   logic            kv_pend;
   logic            kv_issue;
   logic            k_pop;
   logic            v_pop;
   logic            row_complete;
   logic            last_row;
   logic [1:0]      k_count;
   logic [1:0]      v_count;

   assign k_pop = K_vld_out && K_rdy_in;
   assign v_pop = V_vld_out && V_rdy_in;

   // K and V are read in lockstep, so both buffers must have room for the
   // new read on top of whatever is already stored or in flight.
   assign kv_issue = (state == RUN) && (kv_rd_cnt < nkv_lat)
                     && fifo_has_slot(k_count, kv_pend, k_pop)
                     && fifo_has_slot(v_count, kv_pend, v_pop);

   assign k_sram_ren  = kv_issue;
   assign v_sram_ren  = kv_issue;
   assign k_sram_addr = kv_rd_cnt[ADDR_W-1:0];
   assign v_sram_addr = kv_rd_cnt[ADDR_W-1:0];
   assign q_sram_addr = q_row[ADDR_W-1:0];

   // A row is finished once its Q and all K/V handshakes, including any
   // completing this cycle, have been seen.
   always_comb begin
      q_done_next  = q_done | (Q_vld_out & Q_rdy_in);
      k_hs_next    = k_pop ? k_hs_cnt + ONE : k_hs_cnt;
      v_hs_next    = v_pop ? v_hs_cnt + ONE : v_hs_cnt;
      row_complete = (state == RUN) && q_done_next
                     && (k_hs_next == nkv_lat) && (v_hs_next == nkv_lat);
      last_row     = (q_row + ONE) == nq_lat;
   end

   // Pass sequencing, Q read/hold path and per-row bookkeeping.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         nq_lat     <= '0;
         nkv_lat    <= '0;
         q_row      <= '0;
         kv_rd_cnt  <= '0;
         k_hs_cnt   <= '0;
         v_hs_cnt   <= '0;
         q_rd_pend  <= 1'b0;
         q_done     <= 1'b0;
         kv_pend    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         q_sram_ren <= 1'b0;
         Q_vld_out  <= 1'b0;
         q_vector   <= '0;
      end else begin
         done       <= 1'b0;
         q_sram_ren <= 1'b0;
         q_rd_pend  <= q_sram_ren;
         kv_pend    <= kv_issue;
         q_done     <= q_done_next;
         k_hs_cnt   <= k_hs_next;
         v_hs_cnt   <= v_hs_next;

         if (q_rd_pend) begin
            q_vector  <= q_sram_rdata;
            Q_vld_out <= 1'b1;
         end else if (Q_vld_out && Q_rdy_in) begin
            Q_vld_out <= 1'b0;
         end

         if (kv_issue) begin
            kv_rd_cnt <= kv_rd_cnt + ONE;
         end

         case (state)
            IDLE: begin
               if (start) begin
                  nq_lat    <= num_q;
                  nkv_lat   <= num_kv;
                  busy      <= 1'b1;
                  q_row     <= '0;
                  kv_rd_cnt <= '0;
                  k_hs_cnt  <= '0;
                  v_hs_cnt  <= '0;
                  q_done    <= 1'b0;
                  if ((num_q == '0) || (num_kv == '0)) begin
                     state <= FINISH;
                     done  <= 1'b1;
                  end else begin
                     state      <= RUN;
                     q_sram_ren <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (row_complete) begin
                  kv_rd_cnt <= '0;
                  k_hs_cnt  <= '0;
                  v_hs_cnt  <= '0;
                  q_done    <= 1'b0;
                  if (last_row) begin
                     state <= FINISH;
                     done  <= 1'b1;
                  end else begin
                     q_row      <= q_row + ONE;
                     q_sram_ren <= 1'b1;
                  end
               end
            end
            FINISH: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   vec_fifo2 #(.T(K_VECTOR_T)) u_k_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (kv_pend),
      .wr_data (k_sram_rdata),
      .rd_rdy  (K_rdy_in),
      .rd_vld  (K_vld_out),
      .rd_data (k_vector),
      .count   (k_count)
   );

   vec_fifo2 #(.T(V_VECTOR_T)) u_v_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (kv_pend),
      .wr_data (v_sram_rdata),
      .rd_rdy  (V_rdy_in),
      .rd_vld  (V_vld_out),
      .rd_data (v_vector),
      .count   (v_count)
   );

endmodule

// File: tb/tb_qkv_feeder.sv
// Scoreboard bench for qkv_feeder: stimulus pushes expected Q/K/V vectors,
// a negedge monitor pops and compares them on every handshake.
module tb_qkv_feeder;
   import qkv_feeder_pkg::*;

   localparam int ADDR_W     = 4;
   localparam int MAX_CYCLES = 400;

   logic              clk;
   logic              rst;
   logic              start;
   logic [ADDR_W:0]   num_q;
   logic [ADDR_W:0]   num_kv;
   logic              busy;
   logic              done;
   logic              q_sram_ren;
   logic [ADDR_W-1:0] q_sram_addr;
   Q_VECTOR_T         q_sram_rdata;
   logic              k_sram_ren;
   logic [ADDR_W-1:0] k_sram_addr;
   K_VECTOR_T         k_sram_rdata;
   logic              v_sram_ren;
   logic [ADDR_W-1:0] v_sram_addr;
   V_VECTOR_T         v_sram_rdata;
   logic              Q_vld_out;
   logic              Q_rdy_in;
   Q_VECTOR_T         q_vector;
   logic              K_vld_out;
   logic              K_rdy_in;
   K_VECTOR_T         k_vector;
   logic              V_vld_out;
   logic              V_rdy_in;
   V_VECTOR_T         v_vector;

   int checks = 0;
   int passes = 0;
   Q_VECTOR_T q_exp[$];
   K_VECTOR_T k_exp[$];
   V_VECTOR_T v_exp[$];
   int k_hs_cycles[$];
   int cycle = 0;
   int done_count = 0;
   int exp_dones = 0;
   int ren_count = 0;
   int q_ren_count = 0;
   int k_hs_total = 0;
   int v_hs_total = 0;
   int last_hs_cycle = 0;
   int done_cycle = 0;
   int k_rdy_mode = 1;

   qkv_feeder #(.ADDR_W(ADDR_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .num_q        (num_q),
      .num_kv       (num_kv),
      .busy         (busy),
      .done         (done),
      .q_sram_ren   (q_sram_ren),
      .q_sram_addr  (q_sram_addr),
      .q_sram_rdata (q_sram_rdata),
      .k_sram_ren   (k_sram_ren),
      .k_sram_addr  (k_sram_addr),
      .k_sram_rdata (k_sram_rdata),
      .v_sram_ren   (v_sram_ren),
      .v_sram_addr  (v_sram_addr),
      .v_sram_rdata (v_sram_rdata),
      .Q_vld_out    (Q_vld_out),
      .Q_rdy_in     (Q_rdy_in),
      .q_vector     (q_vector),
      .K_vld_out    (K_vld_out),
      .K_rdy_in     (K_rdy_in),
      .k_vector     (k_vector),
      .V_vld_out    (V_vld_out),
      .V_rdy_in     (V_rdy_in),
      .v_vector     (v_vector)
   );

   function automatic logic [31:0] qpat(input int a);
      return 32'h5100_0000 + 32'(a);
   endfunction

   function automatic logic [31:0] kpat(input int a);
      return 32'h6B00_0000 + 32'(a);
   endfunction

   function automatic logic [31:0] vpat(input int a);
      return 32'h7600_0000 + 32'(a);
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // SRAM models with one cycle of read latency
   always @(posedge clk) begin
      if (q_sram_ren) q_sram_rdata <= qpat(int'(q_sram_addr));
      if (k_sram_ren) k_sram_rdata <= kpat(int'(k_sram_addr));
      if (v_sram_ren) v_sram_rdata <= vpat(int'(v_sram_addr));
   end

   // K ready driver: 0 = held low, 1 = held high, 2 = random 50%
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (k_rdy_mode == 2) K_rdy_in = 1'($urandom_range(0, 1));
         else                 K_rdy_in = (k_rdy_mode == 1);
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual === expected) passes++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
   endtask

   task automatic flagFail(input string name, input string why);
      checks++;
      $display("[TB] FAIL %s: %s", name, why);
   endtask

   // Monitor: pops the scoreboard on every completed handshake
   always @(negedge clk) begin
      cycle++;
      if (!rst) begin
         k_hs_total = 0;
         v_hs_total = 0;
      end else begin
         if (q_sram_ren || k_sram_ren || v_sram_ren) ren_count++;
         if (q_sram_ren) q_ren_count++;
         if (done) begin
            done_count++;
            done_cycle = cycle;
         end
         if (Q_vld_out && Q_rdy_in) begin
            last_hs_cycle = cycle;
            if (q_exp.size() == 0) flagFail("Q_unexpected", "handshake with no expected vector");
            else checkOutput("Q_data", q_vector, q_exp.pop_front());
         end
         if (K_vld_out && K_rdy_in) begin
            last_hs_cycle = cycle;
            k_hs_total++;
            k_hs_cycles.push_back(cycle);
            if (k_exp.size() == 0) flagFail("K_unexpected", "handshake with no expected vector");
            else checkOutput("K_data", k_vector, k_exp.pop_front());
         end
         if (V_vld_out && V_rdy_in) begin
            last_hs_cycle = cycle;
            v_hs_total++;
            if (v_exp.size() == 0) flagFail("V_unexpected", "handshake with no expected vector");
            else checkOutput("V_data", v_vector, v_exp.pop_front());
         end
         if ((K_vld_out && K_rdy_in) || (V_vld_out && V_rdy_in))
            checkOutput("KV_skew", 32'((v_hs_total - k_hs_total <= 2) &&
                                       (k_hs_total - v_hs_total <= 2)), 32'd1);
      end
   end

   task automatic applyStimulus(input int nq, input int nkv);
      if (nq > 0 && nkv > 0) begin
         for (int i = 0; i < nq; i++) begin
            q_exp.push_back(qpat(i));
            for (int j = 0; j < nkv; j++) begin
               k_exp.push_back(kpat(j));
               v_exp.push_back(vpat(j));
            end
         end
      end
      num_q  = (ADDR_W+1)'(nq);
      num_kv = (ADDR_W+1)'(nkv);
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      exp_dones++;
      @(negedge clk);
      checkOutput("busy_after_start", 32'(busy), 32'd1);
   endtask

   task automatic waitDone(input string name);
      int base;
      int n;
      base = done_count;
      n = 0;
      while (done_count == base && n < MAX_CYCLES) begin
         @(posedge clk);
         n++;
      end
      if (done_count == base) flagFail(name, "timeout waiting for done");
      #1;
   endtask

   task automatic checkQueuesEmpty(input string tag);
      checkOutput({tag, "_q_left"}, 32'(q_exp.size()), 32'd0);
      checkOutput({tag, "_k_left"}, 32'(k_exp.size()), 32'd0);
      checkOutput({tag, "_v_left"}, 32'(v_exp.size()), 32'd0);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int base;
      int n;
      rst = 1'b0;
      start = 1'b0;
      num_q = '0;
      num_kv = '0;
      Q_rdy_in = 1'b1;
      V_rdy_in = 1'b1;

      repeat (3) @(negedge clk);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_vld", 32'({Q_vld_out, K_vld_out, V_vld_out}), 32'd0);
      checkOutput("rst_ren", 32'({q_sram_ren, k_sram_ren, v_sram_ren}), 32'd0);
      checkOutput("rst_addr", 32'({q_sram_addr, k_sram_addr, v_sram_addr}), 32'd0);
      @(posedge clk);
      #1 rst = 1'b1;

      $display("[TB] one query row, four K/V rows, all ready");
      base = k_hs_cycles.size();
      applyStimulus(1, 4);
      waitDone("t1_done");
      checkOutput("t1_k_count", 32'(k_hs_cycles.size() - base), 32'd4);
      if (k_hs_cycles.size() >= base + 4)
         checkOutput("t1_k_consecutive", 32'(k_hs_cycles[base+3] - k_hs_cycles[base]), 32'd3);
      checkOutput("t1_done_latency", 32'(done_cycle - last_hs_cycle), 32'd1);
      checkQueuesEmpty("t1");

      $display("[TB] two query rows, three K/V rows, random K ready");
      k_rdy_mode = 2;
      applyStimulus(2, 3);
      waitDone("t2_done");
      k_rdy_mode = 1;
      checkQueuesEmpty("t2");

      $display("[TB] Q ready held low for ten cycles");
      Q_rdy_in = 1'b0;
      base = q_ren_count;
      applyStimulus(2, 2);
      n = 0;
      while (!Q_vld_out && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (!Q_vld_out) flagFail("t3_q_valid", "Q_vld_out never rose");
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checkOutput("t3_q_vld_held", 32'(Q_vld_out), 32'd1);
         checkOutput("t3_q_data_held", q_vector, qpat(0));
      end
      checkOutput("t3_row1_not_started", 32'(q_ren_count - base), 32'd1);
      @(posedge clk);
      #1 Q_rdy_in = 1'b1;
      waitDone("t3_done");
      checkQueuesEmpty("t3");

      $display("[TB] zero K/V rows");
      base = ren_count;
      applyStimulus(3, 0);
      checkOutput("t4_done_now", 32'(done), 32'd1);
      @(negedge clk);
      checkOutput("t4_done_gone", 32'(done), 32'd0);
      checkOutput("t4_busy_gone", 32'(busy), 32'd0);
      applyStimulus(0, 5);
      checkOutput("t4b_done_now", 32'(done), 32'd1);
      repeat (3) @(negedge clk);
      checkOutput("t4_no_ren", 32'(ren_count - base), 32'd0);

      $display("[TB] K/V row count at full address range");
      applyStimulus(1, 16);
      waitDone("t5_done");
      checkQueuesEmpty("t5");

      $display("[TB] reset during row 0");
      k_rdy_mode = 0;
      applyStimulus(1, 4);
      n = 0;
      while (!K_vld_out && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (!K_vld_out) flagFail("t6_k_valid", "K_vld_out never rose");
      @(posedge clk);
      #3 rst = 1'b0;
      #1;
      checkOutput("t6_busy", 32'(busy), 32'd0);
      checkOutput("t6_done", 32'(done), 32'd0);
      checkOutput("t6_vld", 32'({Q_vld_out, K_vld_out, V_vld_out}), 32'd0);
      checkOutput("t6_ren", 32'({q_sram_ren, k_sram_ren, v_sram_ren}), 32'd0);
      checkOutput("t6_addr", 32'({q_sram_addr, k_sram_addr, v_sram_addr}), 32'd0);
      q_exp.delete();
      k_exp.delete();
      v_exp.delete();
      exp_dones--;
      @(posedge clk);
      #1 rst = 1'b1;
      k_rdy_mode = 1;
      applyStimulus(1, 1);
      waitDone("t6_restart_done");
      checkQueuesEmpty("t6");

      $display("[TB] start pulsed again while busy");
      applyStimulus(1, 2);
      @(posedge clk);
      #1;
      num_q = (ADDR_W+1)'(3);
      num_kv = (ADDR_W+1)'(3);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      waitDone("t7_done");
      repeat (10) @(posedge clk);
      checkOutput("t7_busy_idle", 32'(busy), 32'd0);
      checkQueuesEmpty("t7");
      checkOutput("done_total", 32'(done_count), 32'(exp_dones));

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
